// File: rtl/ram_sp_async_read_pkg.sv
// Default geometry for the 16x8 scratch RAM.
// Instances that need a different shape override the module parameters.
package ram_sp_async_read_pkg;
   localparam int RAM_DATA_WIDTH = 8;
   localparam int RAM_ADDR_WIDTH = 4;
   localparam int RAM_DEPTH      = 16;
endpackage

// File: rtl/ram_sp_async_read.sv
// Single-port scratch RAM with a synchronous write and a combinational read.
// Reset clears every word in one edge and takes priority over a coincident write.
module ram_sp_async_read
   import ram_sp_async_read_pkg::*;
#(
   parameter int DATA_WIDTH = RAM_DATA_WIDTH,
   parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
   parameter int DEPTH      = RAM_DEPTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic                  write_en,
   output logic [DATA_WIDTH-1:0] data_out
);

   if (DEPTH > 2**ADDR_WIDTH) begin : g_bad_depth
      $error("ram_sp_async_read: DEPTH exceeds the address space");
   end

   // One extra bit so the limit itself is representable when DEPTH == 2**ADDR_WIDTH.
   localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic                  in_range;

   assign in_range = {1'b0, address} < DEPTH_LIM;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (write_en && in_range) begin
         mem[address] <= data_in;
      end
   end

   // Out-of-range addresses read as zero rather than aliasing onto a real word.
   assign data_out = in_range ? mem[address] : '0;

endmodule

// File: tb/tb_ram_sp_async_read.sv
// Randomised and directed checks of the 16x8 async-read RAM against an array model.
module tb_ram_sp_async_read;
   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] data_in;
   logic [3:0] address;
   logic       write_en;
   logic [7:0] data_out;

   logic [7:0] model [16];
   logic       model_valid = 1'b0;
   int         n_cmp = 0;
   int         n_bad = 0;

   ram_sp_async_read dut (
      .clk      (clk),
      .reset    (reset),
      .data_in  (data_in),
      .address  (address),
      .write_en (write_en),
      .data_out (data_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: contents as the spec defines them, updated on each rising edge.
   always @(posedge clk) begin
      if (reset === 1'b1) begin
         for (int i = 0; i < 16; i++) model[i] <= 8'h00;
         model_valid <= 1'b1;
      end else if (write_en === 1'b1) begin
         model[address] <= data_in;
      end
   end

   // Every cycle, mid-period, the read port must show the model word at the current address.
   always @(negedge clk) begin
      if (model_valid) check("cycle_read", data_out, model[address]);
   end

   task automatic write_word(input logic [3:0] a, input logic [7:0] d);
      @(posedge clk); #1;
      write_en = 1'b1; address = a; data_in = d;
      @(posedge clk); #1;
      write_en = 1'b0;
   endtask

   task automatic read_chk(input string name, input logic [3:0] a, input logic [7:0] exp);
      @(posedge clk); #1;
      address = a;
      #1 check(name, data_out, exp);
   endtask

   initial begin
      logic [7:0] d;
      logic [7:0] stored [16];
      int         wide;

      reset = 1'b0; write_en = 1'b0; address = '0; data_in = '0;
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;

      // Reset clears every word
      for (int a = 0; a < 16; a++) read_chk("reset_sweep", 4'(a), 8'h00);

      // Write then read back on the following cycle
      for (int a = 0; a < 16; a++) begin
         d = 8'($urandom);
         stored[a] = d;
         write_word(4'(a), d);
         address = 4'(a);
         #1 check("write_readback", data_out, d);
      end
      for (int a = 0; a < 16; a++) read_chk("readback_all", 4'(a), stored[a]);

      // Fill with i*0x11 and hop address without a clock edge
      for (int a = 0; a < 16; a++) write_word(4'(a), 8'(a * 8'h11));
      @(posedge clk); #1;
      address = 4'd7;
      #1 check("async_addr7", data_out, 8'h77);
      address = 4'd8;
      #1 check("async_addr8", data_out, 8'h88);
      check("model_pin7", model[7], 8'h77);

      // Read-during-write: old word before the edge, new word after
      write_word(4'd5, 8'h3C);
      @(posedge clk); #1;
      write_en = 1'b1; address = 4'd5; data_in = 8'hC3;
      #1 check("rdw_before", data_out, 8'h3C);
      @(posedge clk); #1;
      write_en = 1'b0;
      check("rdw_after", data_out, 8'hC3);
      address = 4'd4;
      #1 check("rdw_neigh4", data_out, 8'h44);
      address = 4'd6;
      #1 check("rdw_neigh6", data_out, 8'h66);

      // Integer 16 on a 4-bit port lands on word 0
      wide = 16;
      write_word(4'(wide), 8'h5A);
      read_chk("wrap_word0", 4'd0, 8'h5A);
      for (int a = 1; a < 16; a++)
         read_chk("wrap_others", 4'(a), (a == 5) ? 8'hC3 : 8'(a * 8'h11));
      check("model_pin0", model[0], 8'h5A);

      // Reset wins over a coincident write
      @(posedge clk); #1;
      reset = 1'b1; write_en = 1'b1; address = 4'd2; data_in = 8'hFF;
      @(posedge clk); #1;
      reset = 1'b0; write_en = 1'b0;
      for (int a = 0; a < 16; a++) read_chk("reset_priority", 4'(a), 8'h00);
      check("model_pin2", model[2], 8'h00);

      // Idle cycles keep contents
      write_word(4'd9, 8'h96);
      write_word(4'd14, 8'hE1);
      repeat (5) @(posedge clk);
      read_chk("idle_hold9", 4'd9, 8'h96);
      read_chk("idle_hold14", 4'd14, 8'hE1);

      // Random traffic, checked every cycle against the model
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         reset    = ($urandom_range(0, 49) == 0);
         write_en = $urandom_range(0, 1) == 1;
         address  = 4'($urandom);
         data_in  = 8'($urandom);
      end
      @(posedge clk); #1;
      reset = 1'b0; write_en = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
